ad_voltage_avg: RTL and testbench

AD_VOLTAGE_AVG -- requirements
Module: ad_voltage_avg

---
 rtl/ad_voltage_avg.sv | 160 ++++++++++++++++
 tb/tb_ad_voltage_avg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ad_voltage_avg.sv
// Block averager for signed 16-bit ADC samples, emitting the floor mean of every 2^AVG_LOG2 strobes.
// Latency: avg_valid rises in the cycle right after the cycle carrying a block's final strobe.
// Backpressure: none; every strobe is taken, including one arriving in the OUT cycle.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   ad_voltage        - signed 16-bit sample, qualified by ad_voltage_valid
//   ad_voltage_valid  - one-cycle sample strobe
//   clear             - synchronous abort of the block in progress (wins over a strobe)
//   avg_voltage       - signed block mean, updated with avg_valid
//   avg_valid         - one-cycle strobe marking updated avg/min/max
//   min_voltage       - signed minimum of the last completed block
//   max_voltage       - signed maximum of the last completed block
//   sample_cnt        - samples accumulated in the current block
//
// Build option: define ADS_MINMAX_EN to track per-block min/max. Without it,
// min_voltage and max_voltage are tied to zero.
module ad_voltage_avg #(
  parameter int AVG_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         ad_voltage,
  input  logic                ad_voltage_valid,
  input  logic                clear,
  output logic [15:0]         avg_voltage,
  output logic                avg_valid,
  output logic [15:0]         min_voltage,
  output logic [15:0]         max_voltage,
  output logic [AVG_LOG2:0]   sample_cnt
);

  // 16 + AVG_LOG2 bits hold the sum of 2^AVG_LOG2 signed 16-bit samples exactly.
  localparam int AW = 16 + AVG_LOG2;

  localparam logic [AVG_LOG2:0] FULL_CNT = {1'b1, {AVG_LOG2{1'b0}}};
  localparam logic [AVG_LOG2:0] ONE_CNT  = {{AVG_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t           state;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    samp_ext;
  logic [AW-1:0]    acc_sum;
  logic [AVG_LOG2:0] cnt_inc;
  logic             block_done;

  assign samp_ext   = {{AVG_LOG2{ad_voltage[15]}}, ad_voltage};
  assign acc_sum    = acc + samp_ext;
  assign cnt_inc    = sample_cnt + 1'b1;
  // The final strobe of a block: only meaningful in ACC with a strobe and no clear.
  assign block_done = (state == ACC) && ad_voltage_valid && !clear && (cnt_inc == FULL_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      sample_cnt  <= '0;
      avg_valid   <= 1'b0;
      avg_voltage <= '0;
    end else begin
      avg_valid <= 1'b0;
      if (clear) begin
        // Abort drops the partial block; published results are left untouched.
        state      <= IDLE;
        acc        <= '0;
        sample_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ad_voltage_valid) begin
              acc        <= samp_ext;
              sample_cnt <= ONE_CNT;
              state      <= ACC;
            end
          end
          ACC: begin
            if (ad_voltage_valid) begin
              acc        <= acc_sum;
              sample_cnt <= cnt_inc;
              if (block_done) begin
                state       <= OUT;
                avg_valid   <= 1'b1;
                // Taking bits above the fraction is an arithmetic shift (floor);
                // the mean always fits back into 16 bits.
                avg_voltage <= acc_sum[AVG_LOG2 +: 16];
              end
            end
          end
          OUT: begin
            // A strobe here opens the next block so back-to-back streams lose nothing.
            if (ad_voltage_valid) begin
              acc        <= samp_ext;
              sample_cnt <= ONE_CNT;
              state      <= ACC;
            end else begin
              acc        <= '0;
              sample_cnt <= '0;
              state      <= IDLE;
            end
          end
          default: begin
            state      <= IDLE;
            acc        <= '0;
            sample_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef ADS_MINMAX_EN
  logic [15:0] run_min;
  logic [15:0] run_max;
  logic [15:0] min_next;
  logic [15:0] max_next;
  logic [15:0] min_reg;
  logic [15:0] max_reg;

  always_comb begin
    min_next = run_min;
    max_next = run_max;
    if ($signed(ad_voltage) < $signed(run_min)) min_next = ad_voltage;
    if ($signed(ad_voltage) > $signed(run_max)) max_next = ad_voltage;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_min <= '0;
      run_max <= '0;
      min_reg <= '0;
      max_reg <= '0;
    end else if (!clear && ad_voltage_valid) begin
      if (state == ACC) begin
        run_min <= min_next;
        run_max <= max_next;
        if (block_done) begin
          min_reg <= min_next;
          max_reg <= max_next;
        end
      end else begin
        // First sample of a block (from IDLE or OUT) seeds both extremes.
        run_min <= ad_voltage;
        run_max <= ad_voltage;
      end
    end
  end

  assign min_voltage = min_reg;
  assign max_voltage = max_reg;
`else
  assign min_voltage = '0;
  assign max_voltage = '0;
`endif

endmodule

// File: tb/tb_ad_voltage_avg.sv
module tb_ad_voltage_avg;
  localparam int L = 4;
  localparam int N = 1 << L;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ad_voltage;
  logic        ad_voltage_valid;
  logic        clear;
  logic [15:0] avg_voltage;
  logic        avg_valid;
  logic [15:0] min_voltage;
  logic [15:0] max_voltage;
  logic [L:0]  sample_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: the open block as a list of sample values, plus the
  // outputs the bench expects to see after the most recent edge.
  int          blk[$];
  logic        exp_valid;
  logic [15:0] exp_avg;
  logic [15:0] exp_min;
  logic [15:0] exp_max;
  int          exp_cnt;

  always #5 clk = ~clk;

  ad_voltage_avg #(.AVG_LOG2(L)) dut (
    .clk              (clk),
    .rst              (rst),
    .ad_voltage       (ad_voltage),
    .ad_voltage_valid (ad_voltage_valid),
    .clear            (clear),
    .avg_voltage      (avg_voltage),
    .avg_valid        (avg_valid),
    .min_voltage      (min_voltage),
    .max_voltage      (max_voltage),
    .sample_cnt       (sample_cnt)
  );

  task automatic model_reset();
    blk.delete();
    exp_valid = 1'b0;
    exp_avg   = 16'h0000;
    exp_min   = 16'h0000;
    exp_max   = 16'h0000;
    exp_cnt   = 0;
  endtask

  // Drive one cycle, advance past the edge, then update the model.
  task automatic step(input logic v, input logic [15:0] d, input logic c);
    int sum, mn, mx, q;
    ad_voltage_valid = v;
    ad_voltage       = v ? d : 16'($urandom);
    clear            = c;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (c) begin
      blk.delete();
    end else if (v) begin
      blk.push_back(int'($signed(d)));
      if (blk.size() == N) begin
        sum = 0; mn = blk[0]; mx = blk[0];
        foreach (blk[i]) begin
          sum += blk[i];
          if (blk[i] < mn) mn = blk[i];
          if (blk[i] > mx) mx = blk[i];
        end
        q = sum / N;
        if ((sum % N) != 0 && sum < 0) q = q - 1;
        exp_avg = 16'(q);
`ifdef ADS_MINMAX_EN
        exp_min = 16'(mn);
        exp_max = 16'(mx);
`endif
        exp_valid = 1'b1;
        blk.delete();
      end
    end
    exp_cnt = exp_valid ? N : blk.size();
  endtask

  task automatic test_reset();
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", avg_valid); end
    checks++; if (avg_voltage !== 16'h0000) begin errors++; $display("FAIL reset_avg got=%h want=0000", avg_voltage); end
    checks++; if (min_voltage !== 16'h0000) begin errors++; $display("FAIL reset_min got=%h want=0000", min_voltage); end
    checks++; if (max_voltage !== 16'h0000) begin errors++; $display("FAIL reset_max got=%h want=0000", max_voltage); end
    checks++; if (sample_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", sample_cnt); end
  endtask

  // Constant, ramp and floor blocks, each followed by an idle cycle.
  task automatic test_patterns();
    logic [15:0] want_avg [3] = '{16'h1000, 16'h0007, 16'hFFFF};
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < N; i++) begin
        logic [15:0] d;
        if (b == 0)      d = 16'h1000;
        else if (b == 1) d = 16'(i);
        else             d = (i < 8) ? 16'hFFFF : 16'h0000;
        step(1'b1, d, 1'b0);
        checks++; if (avg_valid !== exp_valid) begin errors++; $display("FAIL pat%0d_valid i=%0d got=%b want=%b", b, i, avg_valid, exp_valid); end
        checks++; if (sample_cnt !== (L+1)'(exp_cnt)) begin errors++; $display("FAIL pat%0d_cnt i=%0d got=%0d want=%0d", b, i, sample_cnt, exp_cnt); end
      end
      checks++; if (avg_voltage !== want_avg[b]) begin errors++; $display("FAIL pat%0d_avg got=%h want=%h", b, avg_voltage, want_avg[b]); end
      checks++; if (avg_voltage !== exp_avg) begin errors++; $display("FAIL pat%0d_model_avg got=%h want=%h", b, avg_voltage, exp_avg); end
      checks++; if (min_voltage !== exp_min || max_voltage !== exp_max) begin
        errors++; $display("FAIL pat%0d_minmax got=%h/%h want=%h/%h", b, min_voltage, max_voltage, exp_min, exp_max);
      end
`ifdef ADS_MINMAX_EN
      if (b == 1) begin
        checks++; if (min_voltage !== 16'h0000 || max_voltage !== 16'h000F) begin
          errors++; $display("FAIL ramp_minmax got=%h/%h want=0000/000f", min_voltage, max_voltage);
        end
      end
`endif
      step(1'b0, 16'h0, 1'b0);
      checks++; if (avg_valid !== 1'b0 || sample_cnt !== '0) begin errors++; $display("FAIL pat%0d_idle valid=%b cnt=%0d want 0/0", b, avg_valid, sample_cnt); end
      checks++; if (avg_voltage !== want_avg[b]) begin errors++; $display("FAIL pat%0d_hold got=%h want=%h", b, avg_voltage, want_avg[b]); end
    end
  endtask

  task automatic test_clear();
    int pulses = 0;
    logic [15:0] held;
    held = avg_voltage;
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b1, 16'h7FFF, 1'b1);
    checks++; if (sample_cnt !== '0 || avg_valid !== 1'b0) begin errors++; $display("FAIL clear_cnt cnt=%0d valid=%b want 0/0", sample_cnt, avg_valid); end
    checks++; if (avg_voltage !== held) begin errors++; $display("FAIL clear_hold got=%h want=%h", avg_voltage, held); end
    for (int i = 0; i < N; i++) begin
      step(1'b1, 16'h0010, 1'b0);
      if (avg_valid) pulses++;
      checks++; if (avg_valid !== exp_valid) begin errors++; $display("FAIL clear_valid i=%0d got=%b want=%b", i, avg_valid, exp_valid); end
    end
    step(1'b0, 16'h0, 1'b0);
    checks++; if (pulses != 1) begin errors++; $display("FAIL clear_pulses got=%0d want=1", pulses); end
    checks++; if (avg_voltage !== 16'h0010) begin errors++; $display("FAIL clear_avg got=%h want=0010", avg_voltage); end
  endtask

  task automatic test_back_to_back();
    int pulse_at[$];
    for (int i = 0; i < 2 * N; i++) begin
      step(1'b1, 16'h0100, 1'b0);
      if (avg_valid) begin
        pulse_at.push_back(i);
        checks++; if (avg_voltage !== 16'h0100) begin errors++; $display("FAIL b2b_avg i=%0d got=%h want=0100", i, avg_voltage); end
      end
      checks++; if (sample_cnt !== (L+1)'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt i=%0d got=%0d want=%0d", i, sample_cnt, exp_cnt); end
    end
    checks++; if (pulse_at.size() != 2) begin
      errors++; $display("FAIL b2b_pulses got=%0d want=2", pulse_at.size());
    end else begin
      checks++; if (pulse_at[0] != N - 1 || pulse_at[1] - pulse_at[0] != N) begin
        errors++; $display("FAIL b2b_spacing got=%0d,%0d want=%0d,%0d", pulse_at[0], pulse_at[1], N - 1, 2 * N - 1);
      end
    end
    step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_reset_mid_block();
    for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom), 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if (avg_voltage !== 16'h0 || avg_valid !== 1'b0 || sample_cnt !== '0) begin
      errors++; $display("FAIL midrst_out avg=%h valid=%b cnt=%0d want 0", avg_voltage, avg_valid, sample_cnt);
    end
    checks++; if (min_voltage !== 16'h0 || max_voltage !== 16'h0) begin
      errors++; $display("FAIL midrst_minmax got=%h/%h want=0000/0000", min_voltage, max_voltage);
    end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      step(1'b1, 16'h2000, 1'b0);
      checks++; if (avg_valid !== exp_valid) begin errors++; $display("FAIL midrst_valid i=%0d got=%b want=%b", i, avg_valid, exp_valid); end
    end
    checks++; if (avg_voltage !== 16'h2000) begin errors++; $display("FAIL midrst_avg got=%h want=2000", avg_voltage); end
    step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 39) == 0);
      checks++; if (avg_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid i=%0d got=%b want=%b", i, avg_valid, exp_valid); end
      checks++; if (sample_cnt !== (L+1)'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d want=%0d", i, sample_cnt, exp_cnt); end
      checks++; if (avg_voltage !== exp_avg) begin errors++; $display("FAIL rnd_avg i=%0d got=%h want=%h", i, avg_voltage, exp_avg); end
      checks++; if (min_voltage !== exp_min || max_voltage !== exp_max) begin
        errors++; $display("FAIL rnd_minmax i=%0d got=%h/%h want=%h/%h", i, min_voltage, max_voltage, exp_min, exp_max);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ad_voltage = 16'h0;
    ad_voltage_valid = 1'b0;
    clear = 1'b0;
    model_reset();
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    test_patterns();
    test_clear();
    test_back_to_back();
    test_reset_mid_block();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
